// File: rtl/writeback_stage.sv
// MEM/WB writeback stage: retires ALU results and dmem loads into the register file write port,
// counts retired instructions and keeps sticky error flags for misaligned, timed-out and spurious loads.
module writeback_stage #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd_idx,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd_idx,
  output logic [XLEN-1:0] rf_rd_data,
  output logic [63:0]     instret,
  output logic            err_misaligned,
  output logic            err_timeout,
  output logic            err_spurious
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {IDLE, WAIT_RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            ld_reg_write;
  logic [4:0]      ld_rd_idx;
  logic [2:0]      ld_funct3;
  logic [2:0]      ld_addr_lo;

  logic            accept;
  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [XLEN-1:0] wr_data;
  logic            retire;
  logic            capture;
  logic            set_mis;
  logic            set_to;
  logic            set_sp;

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [2:0] a);
    case (f3)
      3'b001, 3'b101: load_misaligned = a[0];
      3'b010, 3'b110: load_misaligned = |a[1:0];
      3'b011:         load_misaligned = |a;
      3'b111:         load_misaligned = 1'b1;
      default:        load_misaligned = 1'b0;
    endcase
  endfunction

  // Lane select from the aligned doubleword; funct3[2] marks the zero-extending variants.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [2:0] a,
                                                    input logic [XLEN-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic        sx;
    b  = d[int'(a) * 8 +: 8];
    h  = d[int'(a[2:1]) * 16 +: 16];
    w  = d[int'(a[2]) * 32 +: 32];
    sx = ~f3[2];
    case (f3[1:0])
      2'b00:   load_extract = {{(XLEN-8){sx & b[7]}}, b};
      2'b01:   load_extract = {{(XLEN-16){sx & h[15]}}, h};
      2'b10:   load_extract = {{(XLEN-32){sx & w[31]}}, w};
      default: load_extract = d;
    endcase
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_idx    = in_rd_idx;
    wr_data   = in_alu_result;
    retire    = 1'b0;
    capture   = 1'b0;
    set_mis   = 1'b0;
    set_to    = 1'b0;
    set_sp    = 1'b0;
    case (state)
      IDLE: begin
        set_sp = dmem_rvalid;
        if (accept) begin
          if (!in_is_load) begin
            retire = 1'b1;
            wr_en  = in_reg_write && (in_rd_idx != 5'd0);
          end else if (load_misaligned(in_funct3, in_addr_lo)) begin
            set_mis = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (dmem_rvalid) begin
          retire    = 1'b1;
          wr_en     = ld_reg_write && (ld_rd_idx != 5'd0);
          wr_idx    = ld_rd_idx;
          wr_data   = load_extract(ld_funct3, ld_addr_lo, dmem_rdata);
          state_nxt = IDLE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted wait cycle: a response arriving now would still have been taken above.
          set_to    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      ld_reg_write   <= 1'b0;
      ld_rd_idx      <= '0;
      ld_funct3      <= '0;
      ld_addr_lo     <= '0;
      rf_we          <= 1'b0;
      rf_rd_idx      <= '0;
      rf_rd_data     <= '0;
      instret        <= '0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      err_spurious   <= 1'b0;
    end else begin
      state <= state_nxt;
      rf_we <= wr_en;
      if (wr_en) begin
        rf_rd_idx  <= wr_idx;
        rf_rd_data <= wr_data;
      end
      if (retire) instret <= instret + 64'd1;
      if (capture) begin
        ld_reg_write <= in_reg_write;
        ld_rd_idx    <= in_rd_idx;
        ld_funct3    <= in_funct3;
        ld_addr_lo   <= in_addr_lo;
        cnt          <= '0;
      end else if (state == WAIT_RESP) begin
        cnt <= cnt + CW'(1);
      end
      err_misaligned <= err_misaligned | set_mis;
      err_timeout    <= err_timeout | set_to;
      err_spurious   <= err_spurious | set_sp;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a randomized run
// compared against a transaction-level model of load extraction and retirement.
module tb_writeback_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, in_reg_write, in_is_load;
  logic [4:0]  in_rd_idx;
  logic [2:0]  in_funct3, in_addr_lo;
  logic [63:0] in_alu_result;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd_idx;
  logic [63:0] rf_rd_data;
  logic [63:0] instret;
  logic        err_misaligned, err_timeout, err_spurious;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_instret;

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  a;
    logic [63:0] d;
    logic [63:0] r;
  } ld_vec_t;

  ld_vec_t vecs [8];

  writeback_stage #(.XLEN(64), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
    .in_rd_idx(in_rd_idx), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data), .instret(instret),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  // Reference: shift the doubleword down to the addressed byte, mask to the access size, extend.
  function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [2:0] a,
                                              input logic [63:0] d);
    int nbytes;
    logic [63:0] v, mask;
    nbytes = 1 << f3[1:0];
    v      = d >> (8 * int'(a));
    mask   = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
    v      = v & mask;
    if (!f3[2] && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic bad_load(input logic [2:0] f3, input logic [2:0] a);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return (f3 == 3'b111) || ((int'(a) % nbytes) != 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_is_load    = 1'b0;
    in_rd_idx     = 5'($urandom);
    in_funct3     = 3'($urandom);
    in_addr_lo    = 3'($urandom);
    in_alu_result = {$urandom, $urandom};
    dmem_rvalid   = 1'b0;
    dmem_rdata    = {$urandom, $urandom};
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic wr, input logic [63:0] d);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_reg_write  = wr;
    in_rd_idx     = rd;
    in_alu_result = d;
    in_funct3     = 3'($urandom);
    in_addr_lo    = 3'($urandom);
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [2:0] a, input logic [4:0] rd,
                            input logic wr);
    in_valid      = 1'b1;
    in_is_load    = 1'b1;
    in_reg_write  = wr;
    in_rd_idx     = rd;
    in_funct3     = f3;
    in_addr_lo    = a;
    in_alu_result = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    logic [137:0] got, want;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    got  = {in_ready, rf_we, rf_rd_idx, rf_rd_data, instret, err_misaligned, err_timeout, err_spurious};
    want = {1'b1, 1'b0, 5'd0, 64'd0, 64'd0, 3'b000};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", got, want);
    end
    rst = 1'b0;
    exp_instret = 64'd0;
  endtask

  task automatic test_alu_stream();
    for (int i = 1; i <= 3; i++) begin
      drive_alu(5'(i), 1'b1, 64'(9 + i));
      tick();
      exp_instret++;
      checks++;
      if ({rf_we, rf_rd_idx, rf_rd_data, instret} !== {1'b1, 5'(i), 64'(9 + i), exp_instret}) begin
        errors++;
        $display("FAIL alu_stream_%0d: got we=%b idx=%0d data=%h instret=%0d want we=1 idx=%0d data=%h instret=%0d",
                 i, rf_we, rf_rd_idx, rf_rd_data, instret, i, 64'(9 + i), exp_instret);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if ({rf_we, rf_rd_idx, rf_rd_data, instret} !== {1'b0, 5'd3, 64'hC, 64'd3}) begin
      errors++;
      $display("FAIL alu_stream_end: got we=%b idx=%0d data=%h instret=%0d want we=0 idx=3 data=c instret=3",
               rf_we, rf_rd_idx, rf_rd_data, instret);
    end
  endtask

  task automatic test_loads();
    for (int i = 0; i < 8; i++) begin
      drive_load(vecs[i].f3, vecs[i].a, 5'(10 + i), 1'b1);
      tick();
      idle_inputs();
      checks++;
      if ({in_ready, rf_we} !== 2'b00) begin
        errors++;
        $display("FAIL load_%0d_accept: got ready=%b we=%b want ready=0 we=0", i, in_ready, rf_we);
      end
      tick();
      checks++;
      if ({in_ready, rf_we} !== 2'b00) begin
        errors++;
        $display("FAIL load_%0d_wait: got ready=%b we=%b want ready=0 we=0", i, in_ready, rf_we);
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = vecs[i].d;
      tick();
      dmem_rvalid = 1'b0;
      exp_instret++;
      checks++;
      if ({rf_we, rf_rd_idx, rf_rd_data, instret, in_ready} !==
          {1'b1, 5'(10 + i), vecs[i].r, exp_instret, 1'b1}) begin
        errors++;
        $display("FAIL load_%0d_data: got we=%b idx=%0d data=%h instret=%0d ready=%b want we=1 idx=%0d data=%h instret=%0d ready=1",
                 i, rf_we, rf_rd_idx, rf_rd_data, instret, in_ready, 10 + i, vecs[i].r, exp_instret);
      end
    end
    tick();
    checks++;
    if ({rf_we, rf_rd_idx, rf_rd_data} !== {1'b0, 5'd17, vecs[7].r}) begin
      errors++;
      $display("FAIL load_hold: got we=%b idx=%0d data=%h want we=0 idx=17 data=%h",
               rf_we, rf_rd_idx, rf_rd_data, vecs[7].r);
    end
  endtask

  task automatic test_misaligned();
    drive_load(3'b001, 3'd3, 5'd7, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if ({err_misaligned, rf_we, in_ready, instret} !== {1'b1, 1'b0, 1'b1, exp_instret}) begin
      errors++;
      $display("FAIL misaligned_lh: got err=%b we=%b ready=%b instret=%0d want err=1 we=0 ready=1 instret=%0d",
               err_misaligned, rf_we, in_ready, instret, exp_instret);
    end
    drive_alu(5'd8, 1'b1, 64'h1234);
    tick();
    exp_instret++;
    checks++;
    if ({rf_we, rf_rd_idx, rf_rd_data, instret} !== {1'b1, 5'd8, 64'h1234, exp_instret}) begin
      errors++;
      $display("FAIL misaligned_next_alu: got we=%b idx=%0d data=%h instret=%0d want we=1 idx=8 data=1234 instret=%0d",
               rf_we, rf_rd_idx, rf_rd_data, instret, exp_instret);
    end
    drive_load(3'b111, 3'd0, 5'd9, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if ({rf_we, in_ready, instret, err_timeout, err_spurious} !== {1'b0, 1'b1, exp_instret, 2'b00}) begin
      errors++;
      $display("FAIL funct3_111: got we=%b ready=%b instret=%0d to=%b sp=%b want we=0 ready=1 instret=%0d to=0 sp=0",
               rf_we, in_ready, instret, err_timeout, err_spurious, exp_instret);
    end
  endtask

  task automatic test_timeout_spurious();
    // Response on the final permitted wait cycle completes normally.
    drive_load(3'b011, 3'd0, 5'd9, 1'b1);
    tick();
    idle_inputs();
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    checks++;
    if ({in_ready, err_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL late_resp_wait: got ready=%b to=%b want ready=0 to=0", in_ready, err_timeout);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    dmem_rvalid = 1'b0;
    exp_instret++;
    checks++;
    if ({rf_we, rf_rd_data, err_timeout, instret} !== {1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, exp_instret}) begin
      errors++;
      $display("FAIL late_resp_done: got we=%b data=%h to=%b instret=%0d want we=1 data=deadbeef0badf00d to=0 instret=%0d",
               rf_we, rf_rd_data, err_timeout, instret, exp_instret);
    end
    drive_load(3'b010, 3'd4, 5'd9, 1'b1);
    tick();
    idle_inputs();
    for (int k = 0; k < TIMEOUT; k++) tick();
    checks++;
    if ({err_timeout, rf_we, in_ready, instret, err_spurious} !== {1'b1, 1'b0, 1'b1, exp_instret, 1'b0}) begin
      errors++;
      $display("FAIL timeout: got to=%b we=%b ready=%b instret=%0d sp=%b want to=1 we=0 ready=1 instret=%0d sp=0",
               err_timeout, rf_we, in_ready, instret, err_spurious, exp_instret);
    end
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({err_spurious, rf_we, instret} !== {1'b1, 1'b0, exp_instret}) begin
      errors++;
      $display("FAIL stray_rvalid: got sp=%b we=%b instret=%0d want sp=1 we=0 instret=%0d",
               err_spurious, rf_we, instret, exp_instret);
    end
  endtask

  task automatic test_x0_and_rst();
    logic [137:0] got, want;
    drive_alu(5'd4, 1'b1, 64'h5555_AAAA_0000_FFFF);
    tick();
    drive_alu(5'd0, 1'b1, 64'h1111);
    tick();
    drive_alu(5'd6, 1'b0, 64'h2222);
    tick();
    idle_inputs();
    exp_instret += 3;
    checks++;
    if ({rf_we, rf_rd_idx, rf_rd_data, instret} !== {1'b0, 5'd4, 64'h5555_AAAA_0000_FFFF, exp_instret}) begin
      errors++;
      $display("FAIL x0_drop: got we=%b idx=%0d data=%h instret=%0d want we=0 idx=4 data=5555aaaa0000ffff instret=%0d",
               rf_we, rf_rd_idx, rf_rd_data, instret, exp_instret);
    end
    drive_load(3'b000, 3'd2, 5'd12, 1'b1);
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got  = {in_ready, rf_we, rf_rd_idx, rf_rd_data, instret, err_misaligned, err_timeout, err_spurious};
    want = {1'b1, 1'b0, 5'd0, 64'd0, 64'd0, 3'b000};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rst_mid_load: got %h want %h", got, want);
    end
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({err_spurious, rf_we, instret} !== {1'b1, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL rvalid_after_rst: got sp=%b we=%b instret=%0d want sp=1 we=0 instret=0",
               err_spurious, rf_we, instret);
    end
  endtask

  task automatic test_random();
    logic        busy, e_we, m_mis, m_to, m_sp;
    logic [4:0]  m_idx, p_rd;
    logic [63:0] m_data, m_instret;
    logic        p_wr;
    logic [2:0]  p_f3, p_a;
    int          waited, plan;
    logic [137:0] got, want;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    busy = 0; m_mis = 0; m_to = 0; m_sp = 0; m_idx = '0; m_data = '0; m_instret = '0;
    p_rd = '0; p_wr = 0; p_f3 = '0; p_a = '0; waited = 0; plan = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_is_load    = 1'($urandom_range(0, 1));
      in_reg_write  = ($urandom_range(0, 7) != 0);
      in_rd_idx     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_funct3     = 3'($urandom);
      in_addr_lo    = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom);
      in_alu_result = {$urandom, $urandom};
      dmem_rdata    = {$urandom, $urandom};
      dmem_rvalid   = busy ? (waited == plan) : ($urandom_range(0, 63) == 0);
      e_we = 1'b0;
      if (busy) begin
        if (dmem_rvalid) begin
          busy = 1'b0;
          m_instret++;
          if (p_wr && p_rd != 5'd0) begin
            e_we   = 1'b1;
            m_idx  = p_rd;
            m_data = load_model(p_f3, p_a, dmem_rdata);
          end
        end else if (waited == TIMEOUT - 1) begin
          busy = 1'b0;
          m_to = 1'b1;
        end else begin
          waited++;
        end
      end else begin
        if (dmem_rvalid) m_sp = 1'b1;
        if (in_valid) begin
          if (!in_is_load) begin
            m_instret++;
            if (in_reg_write && in_rd_idx != 5'd0) begin
              e_we   = 1'b1;
              m_idx  = in_rd_idx;
              m_data = in_alu_result;
            end
          end else if (bad_load(in_funct3, in_addr_lo)) begin
            m_mis = 1'b1;
          end else begin
            busy   = 1'b1;
            waited = 0;
            plan   = int'($urandom_range(0, 17));
            p_wr   = in_reg_write;
            p_rd   = in_rd_idx;
            p_f3   = in_funct3;
            p_a    = in_addr_lo;
          end
        end
      end
      tick();
      got  = {in_ready, rf_we, rf_rd_idx, rf_rd_data, instret, err_misaligned, err_timeout, err_spurious};
      want = {~busy, e_we, m_idx, m_data, m_instret, m_mis, m_to, m_sp};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, got, want);
      end
    end
    idle_inputs();
  endtask

  initial begin
    vecs[0] = '{3'b000, 3'd1, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{3'b100, 3'd1, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0080};
    vecs[2] = '{3'b010, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
    vecs[3] = '{3'b110, 3'd4, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321};
    vecs[4] = '{3'b001, 3'd6, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001};
    vecs[5] = '{3'b101, 3'd6, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001};
    vecs[6] = '{3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[7] = '{3'b000, 3'd7, 64'h7F00_0000_0000_00FF, 64'h0000_0000_0000_007F};
    exp_instret = '0;
    test_reset();
    test_alu_stream();
    test_loads();
    test_misaligned();
    test_timeout_spurious();
    test_x0_and_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
